// File: rtl/bp_cfg_reg_node.sv
// Config-link endpoint: decodes config reads/writes into per-tile control registers and
// forwards the CCE ucode window to an external ucode memory port. One response per command.
module bp_cfg_reg_node #(
  parameter int          cfg_addr_width_p   = 16,
  parameter int          cfg_data_width_p   = 32,
  parameter int          vaddr_width_p      = 39,
  parameter logic [63:0] start_pc_reset_p   = 64'h0000_0000_0008_0000,
  parameter int          ucode_addr_width_p = 8,
  parameter int          cce_ucode_width_p  = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          cfg_v_i,
  input  logic                          cfg_w_i,
  input  logic [cfg_addr_width_p-1:0]   cfg_addr_i,
  input  logic [cfg_data_width_p-1:0]   cfg_data_i,
  output logic                          cfg_ready_o,
  output logic                          cfg_resp_v_o,
  output logic [cfg_data_width_p-1:0]   cfg_resp_data_o,
  output logic                          cfg_resp_err_o,
  input  logic                          cfg_resp_yumi_i,
  output logic                          reset_o,
  output logic                          freeze_o,
  output logic [1:0]                    icache_mode_o,
  output logic [1:0]                    dcache_mode_o,
  output logic                          cce_mode_o,
  output logic [vaddr_width_p-1:0]      start_pc_o,
  output logic                          ucode_v_o,
  output logic                          ucode_w_o,
  output logic [ucode_addr_width_p-1:0] ucode_addr_o,
  output logic [cce_ucode_width_p-1:0]  ucode_data_o,
  input  logic                          ucode_yumi_i,
  input  logic                          ucode_resp_v_i,
  input  logic [cce_ucode_width_p-1:0]  ucode_data_i
);

  typedef enum logic [1:0] {
    READY   = 2'd0,
    UC_REQ  = 2'd1,
    UC_WAIT = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam logic [cfg_addr_width_p-1:0] addr_clk_lp      = 16'h0000;
  localparam logic [cfg_addr_width_p-1:0] addr_reset_lp    = 16'h0001;
  localparam logic [cfg_addr_width_p-1:0] addr_freeze_lp   = 16'h0002;
  localparam logic [cfg_addr_width_p-1:0] addr_icache_lp   = 16'h0022;
  localparam logic [cfg_addr_width_p-1:0] addr_pc_lo_lp    = 16'h0040;
  localparam logic [cfg_addr_width_p-1:0] addr_pc_hi_lp    = 16'h0041;
  localparam logic [cfg_addr_width_p-1:0] addr_dcache_lp   = 16'h0042;
  localparam logic [cfg_addr_width_p-1:0] addr_cce_lp      = 16'h0060;
  localparam logic [cfg_addr_width_p-1:0] uc_base_lp       = 16'h8000;

  state_e                          state_q;
  logic                            ready_q;
  logic                            resp_v_q;
  logic [cfg_data_width_p-1:0]     resp_data_q;
  logic                            resp_err_q;
  logic                            ucode_v_q;
  logic                            uc_w_q;
  logic [ucode_addr_width_p-1:0]   uc_addr_q;
  logic [cce_ucode_width_p-1:0]    uc_data_q;
  logic                            reset_q;
  logic                            freeze_q;
  logic [1:0]                      icache_q;
  logic [1:0]                      dcache_q;
  logic                            cce_q;
  logic [vaddr_width_p-1:0]        start_pc_q;

  logic [cfg_data_width_p-1:0]     rd_val_s;
  logic                            err_s;
  logic                            is_uc_s;
  logic [cfg_addr_width_p-1:0]     uc_off_full_s;
  logic [cfg_data_width_p-1:0]     uc_rdata_s;

  // Address decode: read value of the addressed register, window hit and unmapped flag.
  always_comb begin
    rd_val_s      = '0;
    err_s         = 1'b0;
    uc_off_full_s = cfg_addr_i - uc_base_lp;
    if ((cfg_addr_i >= uc_base_lp) &&
        (uc_off_full_s[cfg_addr_width_p-1:ucode_addr_width_p] == '0)) begin
      is_uc_s = 1'b1;
    end else begin
      is_uc_s = 1'b0;
    end
    case (cfg_addr_i)
      addr_clk_lp:    rd_val_s = '0;
      addr_reset_lp:  rd_val_s[0] = reset_q;
      addr_freeze_lp: rd_val_s[0] = freeze_q;
      addr_icache_lp: rd_val_s[1:0] = icache_q;
      addr_pc_lo_lp:  rd_val_s[31:0] = start_pc_q[31:0];
      addr_pc_hi_lp:  rd_val_s[vaddr_width_p-33:0] = start_pc_q[vaddr_width_p-1:32];
      addr_dcache_lp: rd_val_s[1:0] = dcache_q;
      addr_cce_lp:    rd_val_s[0] = cce_q;
      default:        err_s = ~is_uc_s;
    endcase
  end

  // Ucode read data zero-extended to the config data width.
  always_comb begin
    uc_rdata_s = '0;
    uc_rdata_s[cce_ucode_width_p-1:0] = ucode_data_i;
  end

  // Command FSM together with the control registers and all registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= READY;
      ready_q     <= 1'b1;
      resp_v_q    <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      ucode_v_q   <= 1'b0;
      uc_w_q      <= 1'b0;
      uc_addr_q   <= '0;
      uc_data_q   <= '0;
      reset_q     <= 1'b1;
      freeze_q    <= 1'b1;
      icache_q    <= 2'b00;
      dcache_q    <= 2'b00;
      cce_q       <= 1'b0;
      start_pc_q  <= start_pc_reset_p[vaddr_width_p-1:0];
    end else begin
      case (state_q)
        READY: begin
          if (cfg_v_i) begin
            ready_q <= 1'b0;
            if (is_uc_s) begin
              uc_w_q    <= cfg_w_i;
              uc_addr_q <= uc_off_full_s[ucode_addr_width_p-1:0];
              uc_data_q <= cfg_data_i[cce_ucode_width_p-1:0];
              ucode_v_q <= 1'b1;
              state_q   <= UC_REQ;
            end else begin
              resp_v_q    <= 1'b1;
              resp_err_q  <= err_s;
              resp_data_q <= cfg_w_i ? '0 : rd_val_s;
              state_q     <= RESP;
              if (cfg_w_i) begin
                case (cfg_addr_i)
                  addr_reset_lp:  reset_q  <= cfg_data_i[0];
                  addr_freeze_lp: freeze_q <= cfg_data_i[0];
                  addr_icache_lp: icache_q <= cfg_data_i[1:0];
                  addr_pc_lo_lp:  start_pc_q[31:0] <= cfg_data_i[31:0];
                  addr_pc_hi_lp:  start_pc_q[vaddr_width_p-1:32] <= cfg_data_i[vaddr_width_p-33:0];
                  addr_dcache_lp: dcache_q <= cfg_data_i[1:0];
                  addr_cce_lp:    cce_q    <= cfg_data_i[0];
                  default:        start_pc_q <= start_pc_q;
                endcase
              end
            end
          end
        end
        UC_REQ: begin
          if (ucode_yumi_i) begin
            ucode_v_q <= 1'b0;
            if (uc_w_q) begin
              resp_v_q    <= 1'b1;
              resp_err_q  <= 1'b0;
              resp_data_q <= '0;
              state_q     <= RESP;
            end else begin
              state_q <= UC_WAIT;
            end
          end
        end
        UC_WAIT: begin
          if (ucode_resp_v_i) begin
            resp_v_q    <= 1'b1;
            resp_err_q  <= 1'b0;
            resp_data_q <= uc_rdata_s;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (cfg_resp_yumi_i) begin
            resp_v_q    <= 1'b0;
            resp_err_q  <= 1'b0;
            resp_data_q <= '0;
            ready_q     <= 1'b1;
            state_q     <= READY;
          end
        end
        default: begin
          state_q   <= READY;
          ready_q   <= 1'b1;
          resp_v_q  <= 1'b0;
          ucode_v_q <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready_o     = ready_q;
  assign cfg_resp_v_o    = resp_v_q;
  assign cfg_resp_data_o = resp_data_q;
  assign cfg_resp_err_o  = resp_err_q;
  assign reset_o         = reset_q;
  assign freeze_o        = freeze_q;
  assign icache_mode_o   = icache_q;
  assign dcache_mode_o   = dcache_q;
  assign cce_mode_o      = cce_q;
  assign start_pc_o      = start_pc_q;
  assign ucode_v_o       = ucode_v_q;
  assign ucode_w_o       = uc_w_q;
  assign ucode_addr_o    = uc_addr_q;
  assign ucode_data_o    = uc_data_q;

endmodule

// File: tb/tb_bp_cfg_reg_node.sv
// Randomized bench for bp_cfg_reg_node against a register-map / ucode-memory reference model.
module tb_bp_cfg_reg_node;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        cfg_v_i, cfg_w_i;
  logic [15:0] cfg_addr_i;
  logic [31:0] cfg_data_i;
  logic        cfg_ready_o, cfg_resp_v_o, cfg_resp_err_o;
  logic [31:0] cfg_resp_data_o;
  logic        cfg_resp_yumi_i;
  logic        reset_o, freeze_o, cce_mode_o;
  logic [1:0]  icache_mode_o, dcache_mode_o;
  logic [38:0] start_pc_o;
  logic        ucode_v_o, ucode_w_o, ucode_yumi_i, ucode_resp_v_i;
  logic [7:0]  ucode_addr_o;
  logic [31:0] ucode_data_o, ucode_data_i;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic        m_reset, m_freeze, m_cce;
  logic [1:0]  m_icm, m_dcm;
  logic [63:0] m_spc;
  logic [31:0] mem [256];

  bp_cfg_reg_node dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cfg_v_i(cfg_v_i), .cfg_w_i(cfg_w_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .cfg_ready_o(cfg_ready_o), .cfg_resp_v_o(cfg_resp_v_o), .cfg_resp_data_o(cfg_resp_data_o),
    .cfg_resp_err_o(cfg_resp_err_o), .cfg_resp_yumi_i(cfg_resp_yumi_i),
    .reset_o(reset_o), .freeze_o(freeze_o), .icache_mode_o(icache_mode_o),
    .dcache_mode_o(dcache_mode_o), .cce_mode_o(cce_mode_o), .start_pc_o(start_pc_o),
    .ucode_v_o(ucode_v_o), .ucode_w_o(ucode_w_o), .ucode_addr_o(ucode_addr_o),
    .ucode_data_o(ucode_data_o), .ucode_yumi_i(ucode_yumi_i),
    .ucode_resp_v_i(ucode_resp_v_i), .ucode_data_i(ucode_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset();
    m_reset = 1'b1; m_freeze = 1'b1; m_cce = 1'b0;
    m_icm = 2'd0; m_dcm = 2'd0; m_spc = 64'h0008_0000;
  endtask

  task automatic check_outs(input string where);
    check_val({where, ":reset_o"}, {63'd0, reset_o}, {63'd0, m_reset});
    check_val({where, ":freeze_o"}, {63'd0, freeze_o}, {63'd0, m_freeze});
    check_val({where, ":icache_mode_o"}, {62'd0, icache_mode_o}, {62'd0, m_icm});
    check_val({where, ":dcache_mode_o"}, {62'd0, dcache_mode_o}, {62'd0, m_dcm});
    check_val({where, ":cce_mode_o"}, {63'd0, cce_mode_o}, {63'd0, m_cce});
    check_val({where, ":start_pc_o"}, {25'd0, start_pc_o}, m_spc);
  endtask

  // Register-map semantics: returns expected err/data and applies a write to the model.
  task automatic model_access(input logic w, input logic [15:0] addr, input logic [31:0] d,
                              output logic err, output logic [31:0] rd);
    logic [31:0] cur;
    err = 1'b0;
    cur = 32'd0;
    case (addr)
      16'h0000: cur = 32'd0;
      16'h0001: begin cur = {31'd0, m_reset};  if (w) m_reset  = d[0]; end
      16'h0002: begin cur = {31'd0, m_freeze}; if (w) m_freeze = d[0]; end
      16'h0022: begin cur = {30'd0, m_icm};    if (w) m_icm    = d[1:0]; end
      16'h0040: begin cur = m_spc[31:0];
                      if (w) m_spc = (m_spc & 64'hFFFF_FFFF_0000_0000) | {32'd0, d}; end
      16'h0041: begin cur = 32'(m_spc >> 32);
                      if (w) m_spc = (m_spc % 64'h1_0000_0000) + ({57'd0, d[6:0]} << 32); end
      16'h0042: begin cur = {30'd0, m_dcm};    if (w) m_dcm    = d[1:0]; end
      16'h0060: begin cur = {31'd0, m_cce};    if (w) m_cce    = d[0]; end
      default:  err = 1'b1;
    endcase
    rd = (w || err) ? 32'd0 : cur;
  endtask

  task automatic do_cmd(input logic w, input logic [15:0] addr, input logic [31:0] d,
                        input int yd, input int rd_dly, input int hold);
    logic        is_uc, exp_err;
    logic [31:0] exp_data;
    logic [7:0]  off;
    int          n;
    is_uc = (addr >= 16'h8000) && (addr <= 16'h80FF);
    off   = 8'(addr - 16'h8000);
    n = 0;
    while (!cfg_ready_o && n < 50) begin step(); n++; end
    check_val("cfg_ready_o before cmd", {63'd0, cfg_ready_o}, 64'd1);
    cfg_v_i = 1'b1; cfg_w_i = w; cfg_addr_i = addr; cfg_data_i = d;
    exp_err = 1'b0; exp_data = 32'd0;
    if (!is_uc) model_access(w, addr, d, exp_err, exp_data);
    step();
    cfg_v_i = 1'b0; cfg_data_i = $urandom; cfg_addr_i = 16'($urandom);
    if (is_uc) begin
      for (int i = 0; i <= yd; i++) begin
        check_val("ucode_v_o", {63'd0, ucode_v_o}, 64'd1);
        check_val("ucode_w_o", {63'd0, ucode_w_o}, {63'd0, w});
        check_val("ucode_addr_o", {56'd0, ucode_addr_o}, {56'd0, off});
        if (w) check_val("ucode_data_o", {32'd0, ucode_data_o}, {32'd0, d});
        check_val("cfg_ready_o in ucode", {63'd0, cfg_ready_o}, 64'd0);
        check_val("resp_v in ucode req", {63'd0, cfg_resp_v_o}, 64'd0);
        if (i == yd) ucode_yumi_i = 1'b1;
        step();
      end
      ucode_yumi_i = 1'b0;
      check_val("ucode_v_o after yumi", {63'd0, ucode_v_o}, 64'd0);
      if (w) begin
        mem[off] = d;
      end else begin
        for (int i = 0; i < rd_dly; i++) begin
          check_val("resp_v in ucode wait", {63'd0, cfg_resp_v_o}, 64'd0);
          step();
        end
        ucode_resp_v_i = 1'b1; ucode_data_i = mem[off];
        exp_data = mem[off];
        step();
        ucode_resp_v_i = 1'b0; ucode_data_i = $urandom;
      end
    end
    check_outs("after accept");
    for (int i = 0; i <= hold; i++) begin
      check_val("cfg_resp_v_o", {63'd0, cfg_resp_v_o}, 64'd1);
      check_val("cfg_resp_data_o", {32'd0, cfg_resp_data_o}, {32'd0, exp_data});
      check_val("cfg_resp_err_o", {63'd0, cfg_resp_err_o}, {63'd0, exp_err});
      check_val("cfg_ready_o in resp", {63'd0, cfg_ready_o}, 64'd0);
      if (i == hold) cfg_resp_yumi_i = 1'b1;
      step();
    end
    cfg_resp_yumi_i = 1'b0;
    check_val("resp_v after yumi", {63'd0, cfg_resp_v_o}, 64'd0);
    check_val("ready after yumi", {63'd0, cfg_ready_o}, 64'd1);
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    case ($urandom_range(0, 11))
      0:  a = 16'h0000;
      1:  a = 16'h0001;
      2:  a = 16'h0002;
      3:  a = 16'h0022;
      4:  a = 16'h0040;
      5:  a = 16'h0041;
      6:  a = 16'h0042;
      7:  a = 16'h0060;
      8, 9: a = 16'h8000 + 16'($urandom_range(0, 255));
      10: a = 16'h0100 + 16'($urandom_range(0, 16'h7EFF));
      default: a = 16'h8100 + 16'($urandom_range(0, 16'h7EFF));
    endcase
    return a;
  endfunction

  initial begin
    reset_n_i = 1'b0; cfg_v_i = 1'b0; cfg_w_i = 1'b0; cfg_addr_i = 16'd0; cfg_data_i = 32'd0;
    cfg_resp_yumi_i = 1'b0; ucode_yumi_i = 1'b0; ucode_resp_v_i = 1'b0; ucode_data_i = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    model_reset();
    repeat (3) @(posedge clk_i);
    #3;
    check_val("resp_v in reset", {63'd0, cfg_resp_v_o}, 64'd0);
    check_val("ucode_v in reset", {63'd0, ucode_v_o}, 64'd0);
    reset_n_i = 1'b1;
    step();
    check_outs("post reset");
    check_val("ready post reset", {63'd0, cfg_ready_o}, 64'd1);
    check_val("resp_v post reset", {63'd0, cfg_resp_v_o}, 64'd0);
    check_val("resp_data post reset", {32'd0, cfg_resp_data_o}, 64'd0);
    check_val("resp_err post reset", {63'd0, cfg_resp_err_o}, 64'd0);

    do_cmd(1'b1, 16'h0040, 32'hDEAD_BEEF, 0, 0, 0);
    do_cmd(1'b1, 16'h0041, 32'hFFFF_FF12, 0, 0, 0);
    check_val("start_pc 12_DEADBEEF", {25'd0, start_pc_o}, 64'h12_DEAD_BEEF);
    do_cmd(1'b0, 16'h0041, 32'd0, 0, 0, 0);
    do_cmd(1'b1, 16'h0002, 32'd0, 0, 0, 0);
    do_cmd(1'b1, 16'h0001, 32'd0, 0, 0, 0);
    do_cmd(1'b0, 16'h0123, 32'd0, 0, 0, 0);
    do_cmd(1'b1, 16'h0000, 32'hFFFF_FFFF, 0, 0, 0);
    do_cmd(1'b1, 16'h8005, 32'hA5A5_0001, 3, 0, 0);
    do_cmd(1'b0, 16'h8005, 32'd0, 0, 2, 0);
    do_cmd(1'b0, 16'h0040, 32'd0, 0, 0, 5);
    do_cmd(1'b0, 16'h8100, 32'd0, 0, 0, 0);
    do_cmd(1'b1, 16'h7FFF, 32'h1234_5678, 0, 0, 0);

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        ucode_resp_v_i = 1'b1; ucode_data_i = $urandom;
        step();
        ucode_resp_v_i = 1'b0;
        check_val("stray ucode resp ignored", {63'd0, cfg_resp_v_o}, 64'd0);
      end
      do_cmd(1'($urandom), rand_addr(), $urandom, $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // reset asserted while waiting on ucode read data
    cfg_v_i = 1'b1; cfg_w_i = 1'b0; cfg_addr_i = 16'h8010;
    step();
    cfg_v_i = 1'b0;
    check_val("ucode_v before reset", {63'd0, ucode_v_o}, 64'd1);
    ucode_yumi_i = 1'b1;
    step();
    ucode_yumi_i = 1'b0;
    step();
    #2;
    reset_n_i = 1'b0;
    #1;
    model_reset();
    check_val("async reset ucode_v", {63'd0, ucode_v_o}, 64'd0);
    check_val("async reset resp_v", {63'd0, cfg_resp_v_o}, 64'd0);
    check_outs("async reset");
    #3;
    reset_n_i = 1'b1;
    step();
    check_val("ready after mid reset", {63'd0, cfg_ready_o}, 64'd1);
    ucode_resp_v_i = 1'b1; ucode_data_i = 32'hCAFE_F00D;
    step();
    ucode_resp_v_i = 1'b0;
    check_val("late ucode resp ignored", {63'd0, cfg_resp_v_o}, 64'd0);
    step();
    check_val("still no resp", {63'd0, cfg_resp_v_o}, 64'd0);
    check_outs("after mid reset");
    do_cmd(1'b0, 16'h0001, 32'd0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
